// File: rtl/codec_config_sequencer.sv
// Avalon-MM master that programs the WM8731 codec through the av_config slave.
// It walks the register table, polls each I2C transfer to completion, retries NACKs, and applies volume updates.
module codec_config_sequencer #(
    parameter int         NUM_RETRIES      = 3,
    parameter int         POLL_TIMEOUT     = 4095,
    parameter logic [8:0] SAMPLE_RATE_CTRL = 9'h000,
    parameter logic [6:0] HP_VOL_DEFAULT   = 7'h79
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        vol_wr,
    input  logic [6:0]  vol_data,
    output logic [1:0]  avm_address,
    output logic [3:0]  avm_byteenable,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  err_index
);

    localparam int RW = $clog2(NUM_RETRIES + 2);
    localparam int TW = $clog2(POLL_TIMEOUT + 2);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(NUM_RETRIES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(POLL_TIMEOUT);
    localparam logic [3:0] FIRST_SHORT = 4'd3;
    localparam logic [3:0] LAST_SHORT  = 4'd4;
    localparam logic [3:0] LAST_FULL   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_POLL, S_CHECK, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t          state, state_n;
    logic [3:0]      index, index_n;
    logic [RW-1:0]   retries, retries_n;
    logic [TW-1:0]   timeout_cnt, timeout_n;
    logic [1:0]      status, status_n;
    logic [8:0]      cur_data, cur_data_n;
    logic            short_run, short_n;
    logic            done_n, error_n;
    logic [3:0]      err_index_n;
    logic [6:0]      vol;
    logic            vol_pending;
    logic            launch_vol;
    logic [15:0]     cur_entry;
    logic            unused_readdata;

    // {codec register, codec data} for each table index.
    function automatic logic [15:0] entry(input logic [3:0] idx, input logic [6:0] v);
        case (idx)
            4'd0:    entry = {7'h0F, 9'h000};
            4'd1:    entry = {7'h00, 9'h017};
            4'd2:    entry = {7'h01, 9'h017};
            4'd3:    entry = {7'h02, 2'b01, v};
            4'd4:    entry = {7'h03, 2'b01, v};
            4'd5:    entry = {7'h04, 9'h012};
            4'd6:    entry = {7'h05, 9'h000};
            4'd7:    entry = {7'h06, 9'h000};
            4'd8:    entry = {7'h07, 9'h042};
            4'd9:    entry = {7'h08, SAMPLE_RATE_CTRL};
            4'd10:   entry = {7'h09, 9'h001};
            default: entry = 16'h0000;
        endcase
    endfunction

    assign cur_entry       = entry(index, vol);
    assign avm_byteenable  = 4'hF;
    assign unused_readdata = &{1'b0, avm_readdata[31:2]};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= S_IDLE;
            index       <= 4'd0;
            retries     <= '0;
            timeout_cnt <= '0;
            status      <= 2'b00;
            cur_data    <= 9'h000;
            short_run   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_index   <= 4'd0;
        end else begin
            state       <= state_n;
            index       <= index_n;
            retries     <= retries_n;
            timeout_cnt <= timeout_n;
            status      <= status_n;
            cur_data    <= cur_data_n;
            short_run   <= short_n;
            done        <= done_n;
            error       <= error_n;
            err_index   <= err_index_n;
        end
    end

    // A new vol_wr outranks the clear on launch so the latest value is never dropped.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vol         <= HP_VOL_DEFAULT;
            vol_pending <= 1'b0;
        end else begin
            if (vol_wr) vol <= vol_data;
            if (vol_wr && state != S_ERROR) vol_pending <= 1'b1;
            else if (launch_vol)            vol_pending <= 1'b0;
        end
    end

    // Avalon handshake: a command (read or write, never both) is driven with stable
    // address/data until a cycle where waitrequest=0; that edge completes it.
    always_comb begin
        state_n       = state;
        index_n       = index;
        retries_n     = retries;
        timeout_n     = timeout_cnt;
        status_n      = status;
        cur_data_n    = cur_data;
        short_n       = short_run;
        done_n        = done;
        error_n       = error;
        err_index_n   = err_index;
        launch_vol    = 1'b0;
        avm_address   = 2'd0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'h0;
        busy          = 1'b1;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                busy = 1'b0;
                if (start) begin
                    state_n     = S_WR_ADDR;
                    index_n     = 4'd0;
                    short_n     = 1'b0;
                    retries_n   = '0;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                    err_index_n = 4'd0;
                end else if (state != S_ERROR && vol_pending) begin
                    state_n    = S_WR_ADDR;
                    index_n    = FIRST_SHORT;
                    short_n    = 1'b1;
                    retries_n  = '0;
                    launch_vol = 1'b1;
                end
            end
            S_WR_ADDR: begin
                avm_write     = 1'b1;
                avm_address   = 2'd2;
                avm_writedata = {25'b0, cur_entry[15:9]};
                if (!avm_waitrequest) begin
                    cur_data_n = cur_entry[8:0];
                    state_n    = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                avm_write     = 1'b1;
                avm_address   = 2'd3;
                avm_writedata = {23'b0, cur_data};
                if (!avm_waitrequest) begin
                    state_n   = S_POLL;
                    timeout_n = '0;
                end
            end
            S_POLL: begin
                avm_read    = 1'b1;
                avm_address = 2'd1;
                if (timeout_cnt != '1) timeout_n = timeout_cnt + 1'b1;
                if (!avm_waitrequest) begin
                    status_n = avm_readdata[1:0];
                    state_n  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (timeout_cnt != '1) timeout_n = timeout_cnt + 1'b1;
                if (status[0]) begin
                    if (timeout_cnt >= TIMEOUT_MAX) begin
                        state_n     = S_ERROR;
                        error_n     = 1'b1;
                        err_index_n = index;
                    end else begin
                        state_n = S_POLL;
                    end
                end else if (status[1]) begin
                    if (retries < RETRY_MAX) begin
                        retries_n = retries + 1'b1;
                        state_n   = S_WR_ADDR;
                    end else begin
                        state_n     = S_ERROR;
                        error_n     = 1'b1;
                        err_index_n = index;
                    end
                end else begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                retries_n = '0;
                if (index == (short_run ? LAST_SHORT : LAST_FULL)) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    index_n = index + 4'd1;
                    state_n = S_WR_ADDR;
                end
            end
            default: begin
                state_n = S_IDLE;
                busy    = 1'b0;
            end
        endcase
    end

endmodule
